// File: rtl/eecs151_pkg.sv
// rtl/eecs151_pkg.sv - shared FIFO sizing constants and pointer-width helpers
package eecs151_pkg;

  localparam int FIFO_MIN_DEPTH = 2;
  localparam int MAX_PTR_W      = 32;

  // Widest pointer any FIFO in this slice may use; locals narrow it to AW+1 bits.
  typedef logic [MAX_PTR_W-1:0] ptr_t;

  // Pointer width including the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// rtl/fifo_ram_2p.sv - storage array with one synchronous write port and one asynchronous read port
module fifo_ram_2p #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - first-word-fall-through FIFO with valid/ready on both sides
// Optional occupancy count and almost_full outputs under EECS151_FIFO_LEVEL_EN.
module param_fifo
  import eecs151_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [WIDTH-1:0]        enq_data,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [WIDTH-1:0]        deq_data
`ifdef EECS151_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full
`endif
);

  localparam int AW = ptr_width(DEPTH) - 1;
  localparam logic [AW:0] PTR_ONE = 1;

  if (DEPTH < FIFO_MIN_DEPTH || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("param_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        enq_fire;
  logic        deq_fire;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Flags come from registered pointers only, so no input-to-output path exists.
  assign enq_ready = rst_n && !full;
  assign deq_valid = !empty;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  fifo_ram_2p #(
    .DWIDTH (WIDTH),
    .AWIDTH (AW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (enq_fire),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (enq_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (deq_data)
  );

`ifdef EECS151_FIFO_LEVEL_EN
  localparam logic [AW:0] AF_THR = AF_LVL[AW:0];

  if (AF_LVL < 1 || AF_LVL > DEPTH - 1) begin : g_bad_af
    $error("param_fifo: AF_LVL must lie in 1..DEPTH-1");
  end

  logic [AW:0] level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (enq_fire && !deq_fire) begin
      level <= level + PTR_ONE;
    end else if (deq_fire && !enq_fire) begin
      level <= level - PTR_ONE;
    end
  end

  assign count       = level;
  assign almost_full = (level >= AF_THR);
`endif

endmodule
